// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared constants, state encoding and payload types for the ALU command controller.
package alu_cmd_ctrl_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned ALU_FUNC_WIDTH = 4;
  localparam int unsigned ALU_OUT_WIDTH  = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_OPR  = 8'hCC;
  localparam logic [DATA_WIDTH-1:0] CMD_NOPR = 8'hDD;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_A    = 4'd1,
    ST_GET_B    = 4'd2,
    ST_GET_FUNC = 4'd3,
    ST_ALU_RUN  = 4'd4,
    ST_WAIT_RES = 4'd5,
    ST_SEND_LO  = 4'd6,
    ST_WAIT_LO  = 4'd7,
    ST_SEND_HI  = 4'd8,
    ST_WAIT_HI  = 4'd9
  } state_e;

  typedef enum logic [ALU_FUNC_WIDTH-1:0] {
    FN_ADD    = 4'd0,
    FN_SUB    = 4'd1,
    FN_MUL    = 4'd2,
    FN_DIV    = 4'd3,
    FN_AND    = 4'd4,
    FN_OR     = 4'd5,
    FN_NAND   = 4'd6,
    FN_NOR    = 4'd7,
    FN_XOR    = 4'd8,
    FN_XNOR   = 4'd9,
    FN_CMP_EQ = 4'd10,
    FN_CMP_GT = 4'd11,
    FN_CMP_LT = 4'd12,
    FN_SHR    = 4'd13,
    FN_SHL    = 4'd14
  } alu_func_e;

  // ALU result split into the two bytes sent to the transmitter.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
  } alu_res_t;

  // States in which an incoming RX byte is consumed rather than dropped.
  function automatic logic rx_accepting(state_e s);
    return (s == ST_IDLE) || (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_FUNC);
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of the UART RX/TX and ALU-side signals seen by the command controller.
interface alu_cmd_ctrl_if;
  import alu_cmd_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0]     RX_P_DATA;
  logic                      RX_D_VLD;
  logic [ALU_OUT_WIDTH-1:0]  ALU_OUT;
  logic                      OUT_VALID;
  logic                      TX_BUSY;
  logic [DATA_WIDTH-1:0]     ALU_A;
  logic [DATA_WIDTH-1:0]     ALU_B;
  logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC;
  logic                      ALU_EN;
  logic [DATA_WIDTH-1:0]     TX_P_DATA;
  logic                      TX_D_VLD;
  logic                      RX_DROP;

  // Controller side.
  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_P_DATA, TX_D_VLD, RX_DROP
  );

  // Environment side (UART + ALU).
  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUNC, ALU_EN, TX_P_DATA, TX_D_VLD, RX_DROP
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses CC/DD command frames from UART RX, fires the ALU, and returns the result low byte first.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  alu_cmd_ctrl_if.master bus
);

  state_e                    state_q, state_d;
  logic                      busy_seen_q, busy_seen_d;
  logic [DATA_WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [ALU_FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  alu_res_t                  res_q, res_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                      alu_en_q, alu_en_d;
  logic                      tx_vld_q, tx_vld_d;
  logic                      rx_drop_q, rx_drop_d;
  logic                      tx_fire;

  // All state and registered outputs; reset clears everything, aborting any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      busy_seen_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      res_q       <= '0;
      tx_data_q   <= '0;
      alu_en_q    <= 1'b0;
      tx_vld_q    <= 1'b0;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      res_q       <= res_d;
      tx_data_q   <= tx_data_d;
      alu_en_q    <= alu_en_d;
      tx_vld_q    <= tx_vld_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  // Next-state logic; WAIT_* track a full busy rise/fall of the transmitter before moving on.
  always_comb begin
    state_d     = state_q;
    busy_seen_d = busy_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_OPR)       state_d = ST_GET_A;
          else if (bus.RX_P_DATA == CMD_NOPR) state_d = ST_GET_FUNC;
        end
      end
      ST_GET_A:    if (bus.RX_D_VLD) state_d = ST_GET_B;
      ST_GET_B:    if (bus.RX_D_VLD) state_d = ST_GET_FUNC;
      ST_GET_FUNC: if (bus.RX_D_VLD) state_d = ST_ALU_RUN;
      ST_ALU_RUN:  state_d = ST_WAIT_RES;
      ST_WAIT_RES: if (bus.OUT_VALID) state_d = ST_SEND_LO;
      ST_SEND_LO:  if (!bus.TX_BUSY) state_d = ST_WAIT_LO;
      ST_SEND_HI:  if (!bus.TX_BUSY) state_d = ST_WAIT_HI;
      ST_WAIT_LO, ST_WAIT_HI: begin
        if (!busy_seen_q) begin
          if (bus.TX_BUSY) busy_seen_d = 1'b1;
        end else if (!bus.TX_BUSY) begin
          busy_seen_d = 1'b0;
          state_d     = (state_q == ST_WAIT_LO) ? ST_SEND_HI : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_fire = ((state_q == ST_SEND_LO) || (state_q == ST_SEND_HI)) && !bus.TX_BUSY;

  // Output/datapath logic; operands and result hold between frames so DD can reuse A/B.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    res_d      = res_q;
    tx_data_d  = tx_data_q;
    alu_en_d   = (state_d == ST_ALU_RUN);
    tx_vld_d   = tx_fire;
    rx_drop_d  = bus.RX_D_VLD && !rx_accepting(state_q);
    if (bus.RX_D_VLD && (state_q == ST_GET_A))    alu_a_d    = bus.RX_P_DATA;
    if (bus.RX_D_VLD && (state_q == ST_GET_B))    alu_b_d    = bus.RX_P_DATA;
    if (bus.RX_D_VLD && (state_q == ST_GET_FUNC)) alu_func_d = bus.RX_P_DATA[ALU_FUNC_WIDTH-1:0];
    if (bus.OUT_VALID && (state_q == ST_WAIT_RES)) res_d     = alu_res_t'(bus.ALU_OUT);
    if (tx_fire) tx_data_d = (state_q == ST_SEND_LO) ? res_q.lo : res_q.hi;
  end

  assign bus.ALU_A     = alu_a_q;
  assign bus.ALU_B     = alu_b_q;
  assign bus.ALU_FUNC  = alu_func_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.RX_DROP   = rx_drop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered-ALU model and a simple UART TX model.
module tb_alu_cmd_ctrl;
  import alu_cmd_ctrl_pkg::*;

  logic CLK;
  logic RST;
  alu_cmd_ctrl_if bus();

  alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] txq[$];
  int         en_cnt   = 0;
  int         drop_cnt = 0;
  logic       alu_mute = 1'b0;
  logic       force_busy = 1'b0;
  logic       uart_busy = 1'b0;
  int         uart_cnt = 0;
  logic       pend = 1'b0;
  logic [15:0] pend_val = '0;

  assign bus.TX_BUSY = uart_busy | force_busy;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_model(logic [7:0] a, logic [7:0] b, logic [3:0] f);
    case (f)
      FN_ADD:  return 16'(a) + 16'(b);
      FN_SUB:  return 16'(a) - 16'(b);
      FN_MUL:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Registered ALU: OUT_VALID the cycle after ALU_EN; also counts EN and DROP pulses.
  initial begin
    bus.OUT_VALID = 1'b0;
    bus.ALU_OUT   = '0;
    forever begin
      @(posedge CLK); #1;
      bus.OUT_VALID = pend && !alu_mute;
      bus.ALU_OUT   = pend_val;
      pend     = bus.ALU_EN;
      pend_val = alu_model(bus.ALU_A, bus.ALU_B, bus.ALU_FUNC);
      if (bus.ALU_EN)  en_cnt++;
      if (bus.RX_DROP) drop_cnt++;
    end
  end

  // UART TX: captures each byte and stays busy for five cycles.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (uart_cnt > 0) uart_cnt--;
      if (bus.TX_D_VLD) begin
        txq.push_back(bus.TX_P_DATA);
        uart_cnt = 5;
      end
      uart_busy = (uart_cnt != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_tx(input int n, input string name);
    for (int i = 0; i < 300 && txq.size() < n; i++) @(negedge CLK);
    n_cmp++;
    if (txq.size() < n) begin
      n_fail++;
      $display("FAIL %s_tx_timeout: got %0d bytes want %0d", name, txq.size(), n);
    end
  endtask

  task automatic clear_env();
    txq.delete();
    en_cnt   = 0;
    drop_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = '0;
    wait_cycles(3);
    n_cmp++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUNC} !== 20'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h want 0", {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC});
    end
    n_cmp++;
    if ({bus.ALU_EN, bus.TX_D_VLD, bus.RX_DROP, bus.TX_P_DATA} !== 11'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h want 0", {bus.ALU_EN, bus.TX_D_VLD, bus.RX_DROP, bus.TX_P_DATA});
    end
    @(posedge CLK); #2;
    RST = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_opr();
    clear_env();
    send_byte(8'hCC); send_byte(8'h23); send_byte(8'h05); send_byte(8'h00);
    @(negedge CLK);
    n_cmp++;
    if (bus.ALU_EN !== 1'b1) begin
      n_fail++; $display("FAIL opr_en_latency: got %b want 1", bus.ALU_EN);
    end
    n_cmp++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUNC} !== {8'h23, 8'h05, 4'h0}) begin
      n_fail++; $display("FAIL opr_operands: got %h want 23050", {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC});
    end
    wait_tx(2, "opr");
    wait_cycles(12);
    n_cmp++;
    if (en_cnt !== 1) begin
      n_fail++; $display("FAIL opr_en_count: got %0d want 1", en_cnt);
    end
    n_cmp++;
    if (txq.size() !== 2 || txq[0] !== 8'h28 || txq[1] !== 8'h00) begin
      n_fail++; $display("FAIL opr_tx_bytes: got %0d bytes %h %h want 28 00", txq.size(), txq[0], txq[1]);
    end
  endtask

  task automatic test_nopr();
    clear_env();
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h02);
    wait_tx(2, "nopr_first");
    wait_cycles(12);
    send_byte(8'hDD); send_byte(8'h00);
    wait_tx(4, "nopr_second");
    wait_cycles(12);
    n_cmp++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUNC} !== {8'h10, 8'h20, 4'h0}) begin
      n_fail++; $display("FAIL nopr_operands: got %h want 10200", {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC});
    end
    n_cmp++;
    if (txq.size() !== 4 || {txq[0], txq[1], txq[2], txq[3]} !== 32'h0002_3000) begin
      n_fail++; $display("FAIL nopr_tx_bytes: got %0d bytes %h %h %h %h want 00 02 30 00",
                         txq.size(), txq[0], txq[1], txq[2], txq[3]);
    end
    n_cmp++;
    if (en_cnt !== 2) begin
      n_fail++; $display("FAIL nopr_en_count: got %0d want 2", en_cnt);
    end
  endtask

  task automatic test_busy_hold();
    int vld_seen;
    clear_env();
    vld_seen   = 0;
    force_busy = 1'b1;
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.TX_D_VLD) vld_seen++;
    end
    n_cmp++;
    if (vld_seen !== 0 || txq.size() !== 0) begin
      n_fail++; $display("FAIL busy_holdoff: got %0d pulses want 0", vld_seen);
    end
    @(posedge CLK); #1;
    force_busy = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus.TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL busy_early_fire: got %b want 0", bus.TX_D_VLD);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'h03) begin
      n_fail++; $display("FAIL busy_release_fire: got vld %b data %h want 1 03", bus.TX_D_VLD, bus.TX_P_DATA);
    end
    wait_tx(2, "busy");
    wait_cycles(12);
    n_cmp++;
    if (txq.size() !== 2 || txq[0] !== 8'h03 || txq[1] !== 8'h00) begin
      n_fail++; $display("FAIL busy_tx_bytes: got %0d bytes %h %h want 03 00", txq.size(), txq[0], txq[1]);
    end
  endtask

  task automatic test_ignore();
    clear_env();
    send_byte(8'h55);
    wait_cycles(3);
    n_cmp++;
    if (drop_cnt !== 0 || en_cnt !== 0) begin
      n_fail++; $display("FAIL ignore_idle_byte: got drop %0d en %0d want 0 0", drop_cnt, en_cnt);
    end
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h08); send_byte(8'h00);
    wait_tx(2, "ignore");
    wait_cycles(12);
    n_cmp++;
    if (txq.size() !== 2 || txq[0] !== 8'h0F || txq[1] !== 8'h00 || en_cnt !== 1) begin
      n_fail++; $display("FAIL ignore_frame: got %0d bytes %h %h en %0d want 0f 00 en 1",
                         txq.size(), txq[0], txq[1], en_cnt);
    end
  endtask

  task automatic test_drop();
    clear_env();
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    wait_tx(1, "drop_lo");
    send_byte(8'hAA);
    wait_cycles(2);
    n_cmp++;
    if (drop_cnt !== 1) begin
      n_fail++; $display("FAIL drop_pulse: got %0d want 1", drop_cnt);
    end
    wait_tx(2, "drop_hi");
    wait_cycles(12);
    n_cmp++;
    if (txq.size() !== 2 || txq[0] !== 8'h05 || txq[1] !== 8'h00) begin
      n_fail++; $display("FAIL drop_tx_bytes: got %0d bytes %h %h want 05 00", txq.size(), txq[0], txq[1]);
    end
    n_cmp++;
    if ({bus.ALU_A, bus.ALU_B} !== 16'h0203 || en_cnt !== 1) begin
      n_fail++; $display("FAIL drop_state: got %h en %0d want 0203 en 1", {bus.ALU_A, bus.ALU_B}, en_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_env();
    alu_mute = 1'b1;
    send_byte(8'hCC); send_byte(8'h04); send_byte(8'h05); send_byte(8'h00);
    wait_cycles(4);
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUNC, bus.ALU_EN, bus.TX_D_VLD, bus.RX_DROP} !== 23'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0",
                         {bus.ALU_A, bus.ALU_B, bus.ALU_FUNC, bus.ALU_EN, bus.TX_D_VLD, bus.RX_DROP});
    end
    wait_cycles(2);
    @(posedge CLK); #2;
    RST = 1'b1;
    alu_mute = 1'b0;
    wait_cycles(2);
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h03); send_byte(8'h01);
    wait_tx(2, "midreset");
    wait_cycles(12);
    n_cmp++;
    if (txq.size() !== 2 || txq[0] !== 8'h06 || txq[1] !== 8'h00) begin
      n_fail++; $display("FAIL midreset_tx_bytes: got %0d bytes %h %h want 06 00", txq.size(), txq[0], txq[1]);
    end
  endtask

  initial begin
    test_reset();
    test_opr();
    test_nopr();
    test_busy_hold();
    test_ignore();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
